// File: rtl/sch_test_slave_if.sv
// Signal bundle for the SPI loopback block: start/data inputs, link pins,
// received words and the exported internal shift state.
interface sch_test_slave_if #(
    parameter int WIDTH = 9
);
    logic             st;
    logic [WIDTH-1:0] MTX_DAT;
    logic [WIDTH-1:0] STX_DAT;
    logic             LOAD;
    logic             SCLK;
    logic             MOSI;
    logic             MISO;
    logic [WIDTH-1:0] MRX_DAT;
    logic [WIDTH-1:0] SRX_DAT;
    logic [WIDTH-1:0] sr_MTX;
    logic [WIDTH-1:0] sr_MRX;
    logic [WIDTH-1:0] sr_STX;
    logic [WIDTH-1:0] sr_SRX;
    logic [7:0]       cb_bit;
    logic             ce_tact;

    modport slave (
        input  st, MTX_DAT, STX_DAT,
        output LOAD, SCLK, MOSI, MISO, MRX_DAT, SRX_DAT,
               sr_MTX, sr_MRX, sr_STX, sr_SRX, cb_bit, ce_tact
    );

    modport master (
        output st, MTX_DAT, STX_DAT,
        input  LOAD, SCLK, MOSI, MISO, MRX_DAT, SRX_DAT,
               sr_MTX, sr_MRX, sr_STX, sr_SRX, cb_bit, ce_tact
    );
endinterface

// File: rtl/sch_test_slave.sv
// SPI mode-0 loopback: a master and a slave swap one WIDTH-bit word per start.
// state   | meaning
// S_IDLE  | LOAD low, SCLK low, divider parked, waiting for st
// S_FRAME | LOAD high, SCLK toggles every DIV clks until WIDTH bits complete
module sch_test_slave #(
    parameter int WIDTH = 9,
    parameter int DIV   = 25
) (
    input  logic               clk,
    input  logic               RESET,
    sch_test_slave_if.slave    bus
);
    localparam int DW = $clog2(DIV);

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    div_cnt;
    logic             load;
    logic             ce;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             frame_start;
    logic             frame_end;
    logic [7:0]       cb_bit;
    logic [WIDTH-1:0] sr_mtx;
    logic [WIDTH-1:0] sr_mrx;
    logic [WIDTH-1:0] sr_stx;
    logic [WIDTH-1:0] sr_srx;
    logic [WIDTH-1:0] mrx_dat;
    logic [WIDTH-1:0] srx_dat;
    logic             load_d;
    logic             sclk_d;

    assign load        = (state == S_FRAME);
    assign ce          = load && (div_cnt == '0);
    assign mosi        = sr_mtx[WIDTH-1];
    assign miso        = sr_stx[WIDTH-1];
    assign frame_start = (state == S_IDLE) && bus.st;
    assign frame_end   = ce && sclk && (cb_bit == 8'(WIDTH-1));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.st)   state_nxt = S_FRAME;
            S_FRAME: if (frame_end) state_nxt = S_IDLE;
        endcase
    end

    // Down-counter: terminal count 0 is the ce strobe, DIV clks apart.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)           div_cnt <= '0;
        else if (frame_start) div_cnt <= DW'(DIV-1);
        else if (!load)       div_cnt <= '0;
        else if (ce)          div_cnt <= DW'(DIV-1);
        else                  div_cnt <= div_cnt - DW'(1);
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sclk    <= 1'b0;
            sr_mtx  <= '0;
            sr_mrx  <= '0;
            cb_bit  <= '0;
            mrx_dat <= '0;
        end else if (frame_start) begin
            sclk   <= 1'b0;
            sr_mtx <= bus.MTX_DAT;
            cb_bit <= '0;
        end else if (ce) begin
            if (!sclk) begin
                sclk   <= 1'b1;
                sr_mrx <= {sr_mrx[WIDTH-2:0], miso};
            end else begin
                sclk   <= 1'b0;
                sr_mtx <= {sr_mtx[WIDTH-2:0], 1'b0};
                cb_bit <= cb_bit + 8'd1;
                if (frame_end) mrx_dat <= sr_mrx;
            end
        end
    end

    // Slave sees only the pins, one clk late through its edge detectors.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            load_d  <= 1'b0;
            sclk_d  <= 1'b0;
            sr_stx  <= '0;
            sr_srx  <= '0;
            srx_dat <= '0;
        end else begin
            load_d <= load;
            sclk_d <= sclk;
            if (load && !load_d)      sr_stx <= bus.STX_DAT;
            else if (!sclk && sclk_d) sr_stx <= {sr_stx[WIDTH-2:0], 1'b0};
            if (sclk && !sclk_d)      sr_srx <= {sr_srx[WIDTH-2:0], mosi};
            if (!load && load_d)      srx_dat <= sr_srx;
        end
    end

    assign bus.LOAD    = load;
    assign bus.SCLK    = sclk;
    assign bus.MOSI    = mosi;
    assign bus.MISO    = miso;
    assign bus.MRX_DAT = mrx_dat;
    assign bus.SRX_DAT = srx_dat;
    assign bus.sr_MTX  = sr_mtx;
    assign bus.sr_MRX  = sr_mrx;
    assign bus.sr_STX  = sr_stx;
    assign bus.sr_SRX  = sr_srx;
    assign bus.cb_bit  = cb_bit;
    assign bus.ce_tact = ce;
endmodule

// File: tb/tb_sch_test_slave.sv
// Bench for sch_test_slave: directed and random frames against a word-level
// model (each side receives the other's word, MSB first, fixed frame length).
module tb_sch_test_slave;
    localparam int WIDTH      = 9;
    localparam int DIV        = 25;
    localparam int FRAME_CLKS = 2 * WIDTH * DIV;

    logic clk   = 1'b0;
    logic RESET = 1'b0;
    always #10 clk = ~clk;

    sch_test_slave_if #(.WIDTH(WIDTH)) bus ();

    sch_test_slave #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_mrx = '0;
    logic [WIDTH-1:0] exp_srx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_load"},   32'(bus.LOAD),    0);
        chk({tag, "_sclk"},   32'(bus.SCLK),    0);
        chk({tag, "_mosi"},   32'(bus.MOSI),    0);
        chk({tag, "_miso"},   32'(bus.MISO),    0);
        chk({tag, "_mrx"},    32'(bus.MRX_DAT), 0);
        chk({tag, "_srx"},    32'(bus.SRX_DAT), 0);
        chk({tag, "_srmtx"},  32'(bus.sr_MTX),  0);
        chk({tag, "_srmrx"},  32'(bus.sr_MRX),  0);
        chk({tag, "_srstx"},  32'(bus.sr_STX),  0);
        chk({tag, "_srsrx"},  32'(bus.sr_SRX),  0);
        chk({tag, "_cbbit"},  32'(bus.cb_bit),  0);
        chk({tag, "_cetact"}, 32'(bus.ce_tact), 0);
    endtask

    task automatic run_frame(input logic [WIDTH-1:0] mtx, input logic [WIDTH-1:0] stx,
                             input bit poke);
        int cnt;
        int rises;
        logic prev_sclk, prev_mosi, prev_miso;
        @(negedge clk);
        bus.MTX_DAT = mtx;
        bus.STX_DAT = stx;
        bus.st      = 1'b1;
        @(negedge clk);
        bus.st = 1'b0;
        chk("load_rise", 32'(bus.LOAD), 1);
        chk("mrx_hold", 32'(bus.MRX_DAT), 32'(exp_mrx));
        chk("srx_hold", 32'(bus.SRX_DAT), 32'(exp_srx));
        cnt       = 0;
        rises     = 0;
        prev_sclk = bus.SCLK;
        prev_mosi = bus.MOSI;
        prev_miso = bus.MISO;
        while (bus.LOAD && cnt < FRAME_CLKS + 100) begin
            cnt++;
            if (bus.SCLK && !prev_sclk) begin
                if (rises < WIDTH) begin
                    chk("mosi_pre",  32'(prev_mosi), 32'(mtx[WIDTH-1-rises]));
                    chk("mosi_post", 32'(bus.MOSI),  32'(mtx[WIDTH-1-rises]));
                    chk("miso_pre",  32'(prev_miso), 32'(stx[WIDTH-1-rises]));
                    chk("miso_post", 32'(bus.MISO),  32'(stx[WIDTH-1-rises]));
                end
                rises++;
            end
            if (cnt == 5) begin
                bus.MTX_DAT = WIDTH'($urandom);
                bus.STX_DAT = WIDTH'($urandom);
            end
            if (poke && cnt == 200) bus.st = 1'b1;
            if (poke && cnt == 201) bus.st = 1'b0;
            prev_sclk = bus.SCLK;
            prev_mosi = bus.MOSI;
            prev_miso = bus.MISO;
            @(negedge clk);
        end
        bus.st = 1'b0;
        chk("frame_len", 32'(cnt), 32'(FRAME_CLKS));
        chk("sclk_rises", 32'(rises), 32'(WIDTH));
        chk("mrx_dat", 32'(bus.MRX_DAT), 32'(stx));
        exp_mrx = stx;
        @(negedge clk);
        @(negedge clk);
        chk("srx_dat", 32'(bus.SRX_DAT), 32'(mtx));
        exp_srx = mtx;
        chk("post_srmtx", 32'(bus.sr_MTX),  0);
        chk("post_srstx", 32'(bus.sr_STX),  0);
        chk("post_mosi",  32'(bus.MOSI),    0);
        chk("post_miso",  32'(bus.MISO),    0);
        chk("post_cbbit", 32'(bus.cb_bit),  32'(WIDTH));
        chk("post_sclk",  32'(bus.SCLK),    0);
        chk("post_load",  32'(bus.LOAD),    0);
        chk("post_ce",    32'(bus.ce_tact), 0);
    endtask

    task automatic reset_mid_frame(input logic [WIDTH-1:0] mtx, input logic [WIDTH-1:0] stx);
        int guard;
        @(negedge clk);
        bus.MTX_DAT = mtx;
        bus.STX_DAT = stx;
        bus.st      = 1'b1;
        @(negedge clk);
        bus.st = 1'b0;
        guard  = 0;
        while (bus.cb_bit != 8'd4 && guard < 2 * FRAME_CLKS) begin
            guard++;
            @(negedge clk);
        end
        chk("cb_reach4", 32'(bus.cb_bit), 4);
        #3 RESET = 1'b0;
        #1;
        chk("rst_load", 32'(bus.LOAD),    0);
        chk("rst_sclk", 32'(bus.SCLK),    0);
        chk("rst_mrx",  32'(bus.MRX_DAT), 0);
        chk("rst_srx",  32'(bus.SRX_DAT), 0);
        chk("rst_cb",   32'(bus.cb_bit),  0);
        exp_mrx = '0;
        exp_srx = '0;
        @(negedge clk);
        RESET = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] m, s;
        bus.st      = 1'b0;
        bus.MTX_DAT = '0;
        bus.STX_DAT = '0;
        RESET       = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_load", 32'(bus.LOAD), 0);
        chk("idle_sclk", 32'(bus.SCLK), 0);
        chk("idle_ce",   32'(bus.ce_tact), 0);

        run_frame(9'b101111010, 9'b111011011, 1'b0);
        run_frame(9'b101111010, 9'b111011011, 1'b1);

        @(negedge clk);
        #2 RESET = 1'b0;
        #20;
        check_all_zero("idle_rst");
        exp_mrx = '0;
        exp_srx = '0;
        RESET = 1'b1;

        reset_mid_frame(9'b101111010, 9'b111011011);
        run_frame(9'b101111010, 9'b111011011, 1'b0);

        run_frame(9'h1FF, 9'h000, 1'b0);
        run_frame(9'h000, 9'h1FF, 1'b0);

        for (int i = 0; i < 6; i++) begin
            m = WIDTH'($urandom);
            s = WIDTH'($urandom);
            run_frame(m, s, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
